flit_splitter_hs: RTL and testbench

// Parametrised successor to the fixed 68b/4-flit packet splitter in the NoC network-interface path.
// - Accepts whole packets on a valid/ready port and buffers them in a FIFO of QUEUE_DEPTH.
// - Serialises each packet MSB-first into FLITS flits, each carrying a mesh-coordinate header.
// - Adds output backpressure (out_ready), out-of-range destination rejection, a last-flit marker
//   and generic mesh/width parameters.

---
 rtl/flit_splitter_hs_if.sv | 40 ++++
 rtl/flit_splitter_hs.sv | 152 +++++++++++++++
 tb/tb_flit_splitter_hs.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flit_splitter_hs_if.sv
// Packet-in / flit-out handshake bundle for flit_splitter_hs.
// slave = splitter side, master = traffic source/sink side.
interface flit_splitter_hs_if #(
  parameter int MESH_X          = 3,
  parameter int MESH_Y          = 3,
  parameter int PACKET_W        = 68,
  parameter int FLIT_PAYLOAD_W  = 17,
  parameter int PACKET_ID_WIDTH = 5
);
  localparam int NODE_W = $clog2(MESH_X * MESH_Y);
  localparam int CXW    = $clog2(MESH_X);
  localparam int CYW    = $clog2(MESH_Y);
  localparam int CXY    = (CXW > CYW) ? CXW : CYW;
  localparam int CW     = (CXY > 1) ? CXY : 1;
  localparam int FLITS  =
    (PACKET_W + FLIT_PAYLOAD_W - 1) / FLIT_PAYLOAD_W;
  localparam int IDX_W  = $clog2(FLITS);
  localparam int FLIT_W = 1 + 2 * CW + FLIT_PAYLOAD_W
                        + PACKET_ID_WIDTH + NODE_W + IDX_W;

  logic                       in_valid;
  logic                       in_ready;
  logic [PACKET_W-1:0]        in_packet;
  logic [NODE_W-1:0]          in_dest;
  logic [PACKET_ID_WIDTH-1:0] in_id;
  logic                       out_valid;
  logic                       out_ready;
  logic [FLIT_W-1:0]          out_flit;
  logic                       out_last;

  modport slave (
    input  in_valid, in_packet, in_dest, in_id, out_ready,
    output in_ready, out_valid, out_flit, out_last
  );

  modport master (
    output in_valid, in_packet, in_dest, in_id, out_ready,
    input  in_ready, out_valid, out_flit, out_last
  );
endinterface

// File: rtl/flit_splitter_hs.sv
// Buffers whole packets in a FIFO and serialises each MSB-first
// into mesh flits. Ports: clk, rst_n (sync), ce, bus (slave:
// packet in / flit out handshakes), count (FIFO fill), drop_err.
module flit_splitter_hs #(
  parameter int NODE_ID         = 0,
  parameter int MESH_X          = 3,
  parameter int MESH_Y          = 3,
  parameter int PACKET_W        = 68,
  parameter int FLIT_PAYLOAD_W  = 17,
  parameter int QUEUE_DEPTH     = 8,
  parameter int PACKET_ID_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ce,
  flit_splitter_hs_if.slave          bus,
  output logic [$clog2(QUEUE_DEPTH):0] count,
  output logic                       drop_err
);
  localparam int NODE_COUNT = MESH_X * MESH_Y;
  localparam int NODE_W = $clog2(NODE_COUNT);
  localparam int CXW    = $clog2(MESH_X);
  localparam int CYW    = $clog2(MESH_Y);
  localparam int CXY    = (CXW > CYW) ? CXW : CYW;
  localparam int CW     = (CXY > 1) ? CXY : 1;
  localparam int FLITS  =
    (PACKET_W + FLIT_PAYLOAD_W - 1) / FLIT_PAYLOAD_W;
  localparam int IDX_W  = $clog2(FLITS);
  localparam int FLIT_W = 1 + 2 * CW + FLIT_PAYLOAD_W
                        + PACKET_ID_WIDTH + NODE_W + IDX_W;
  localparam int PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int PADW   = FLITS * FLIT_PAYLOAD_W;
  localparam int PAD_SH = PADW - PACKET_W;

  localparam logic [NODE_W:0] NC = (NODE_W+1)'(NODE_COUNT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FLITS - 1);

  typedef struct packed {
    logic [PACKET_W-1:0]        pkt;
    logic [CW-1:0]              dx;
    logic [CW-1:0]              dy;
    logic [PACKET_ID_WIDTH-1:0] id;
  } entry_t;

  entry_t mem [QUEUE_DEPTH];
  entry_t entry_in;
  entry_t head;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic              full_r;
  logic [FLIT_W-1:0] flit_r;
  logic              last_r;
  logic              drop_r;

  logic dest_ok;
  logic hs_in;
  logic push;
  logic load;
  logic last_load;
  int   dest_i;

  logic [PADW-1:0]           padded;
  logic [PADW-1:0]           shifted;
  logic [FLIT_PAYLOAD_W-1:0] payload;
  logic [FLIT_W-1:0]         next_flit;

  assign bus.in_ready = rst_n && ce
                     && (cnt < CNT_W'(QUEUE_DEPTH));

  assign dest_ok = {1'b0, bus.in_dest} < NC;
  assign hs_in   = bus.in_valid && bus.in_ready;
  assign push    = hs_in && dest_ok;

  // Refill the output register whenever it is, or is about
  // to become, empty and a packet is waiting.
  assign load = ce && (cnt != '0)
             && (!full_r || bus.out_ready);
  assign last_load = load && (idx == IDX_LAST);

  always_comb begin
    dest_i       = int'(bus.in_dest);
    entry_in.pkt = bus.in_packet;
    entry_in.dx  = CW'(dest_i % MESH_X);
    entry_in.dy  = CW'(dest_i / MESH_X);
    entry_in.id  = bus.in_id;
  end

  // Left-align the packet so the short tail flit is
  // zero-padded at its LSBs.
  always_comb begin
    head      = mem[rd_ptr];
    padded    = PADW'(head.pkt) << PAD_SH;
    shifted   = padded << (int'(idx) * FLIT_PAYLOAD_W);
    payload   = shifted[PADW-1 -: FLIT_PAYLOAD_W];
    next_flit = {1'b1, head.dx, head.dy, payload,
                 head.id, NODE_W'(NODE_ID), idx};
  end

  always_ff @(posedge clk) begin
    if (ce && push) begin
      mem[wr_ptr] <= entry_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      idx    <= '0;
      full_r <= 1'b0;
      flit_r <= '0;
      last_r <= 1'b0;
      drop_r <= 1'b0;
    end else if (ce) begin
      drop_r <= hs_in && !dest_ok;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (last_load) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, last_load})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      if (load) begin
        full_r <= 1'b1;
        flit_r <= next_flit;
        last_r <= (idx == IDX_LAST);
        idx    <= (idx == IDX_LAST) ? '0
                : idx + IDX_W'(1);
      end else if (full_r && bus.out_ready) begin
        full_r <= 1'b0;
        flit_r <= '0;
        last_r <= 1'b0;
      end
    end
  end

  assign bus.out_valid = full_r && ce;
  assign bus.out_flit  = flit_r;
  assign bus.out_last  = last_r;
  assign count         = cnt;
  assign drop_err      = drop_r && ce;

endmodule

// File: tb/tb_flit_splitter_hs.sv
// Scoreboard bench for flit_splitter_hs: directed scenarios
// followed by randomized traffic, ce gating and reset.
module tb_flit_splitter_hs;
  localparam int PW    = 68;
  localparam int FPW   = 17;
  localparam int FLITS = 4;
  localparam int FW    = 33;
  localparam int NODES = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b0;
  logic [3:0] count;
  logic       drop_err;

  always #5 clk = ~clk;

  flit_splitter_hs_if bus();

  flit_splitter_hs dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .bus      (bus),
    .count    (count),
    .drop_err (drop_err)
  );

  int errs = 0;
  int checks = 0;

  typedef struct {
    logic [FW-1:0] f;
    logic          l;
  } exp_t;

  exp_t sbq[$];
  logic exp_drop = 1'b0;
  bit   hold = 1'b0;
  logic [FW:0] held;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Reference: split by absolute bit position, MSB first.
  function automatic void model_push(logic [PW-1:0] p,
                                     logic [3:0] d,
                                     logic [4:0] id);
    exp_t e;
    logic [FPW-1:0] pay;
    logic [1:0] dx;
    logic [1:0] dy;
    int pos;
    dx = 2'(int'(d) % 3);
    dy = 2'(int'(d) / 3);
    for (int k = 0; k < FLITS; k++) begin
      pay = '0;
      for (int b = 0; b < FPW; b++) begin
        pos = PW - 1 - k * FPW - b;
        if (pos >= 0) pay[FPW-1-b] = p[pos];
      end
      e.f = {1'b1, dx, dy, pay, id, 4'd0, 2'(k)};
      e.l = (k == FLITS - 1);
      sbq.push_back(e);
    end
  endfunction

  // Stimulus side: record every accepted packet.
  always @(negedge clk) begin
    if (rst_n && ce)
      chk("drop_err", 64'(drop_err), 64'(exp_drop));
    if (bus.in_valid && bus.in_ready
        && int'(bus.in_dest) < NODES)
      model_push(bus.in_packet, bus.in_dest, bus.in_id);
    if (!rst_n)
      exp_drop = 1'b0;
    else if (ce)
      exp_drop = bus.in_valid && bus.in_ready
              && int'(bus.in_dest) >= NODES;
  end

  // Monitor side: compare each delivered flit.
  always @(negedge clk) begin
    exp_t e;
    if (hold && bus.out_valid)
      chk("hold_stable", 64'({bus.out_last, bus.out_flit}),
          64'(held));
    if (bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_flit", 64'(bus.out_flit), 64'(0));
      end else begin
        e = sbq.pop_front();
        chk("flit", 64'(bus.out_flit), 64'(e.f));
        chk("last", 64'(bus.out_last), 64'(e.l));
      end
    end else if (rst_n && ce && !bus.out_valid) begin
      chk("idle_flit", 64'(bus.out_flit), 64'(0));
    end
    if (!rst_n) begin
      hold = 1'b0;
      sbq.delete();
    end else if (bus.out_valid) begin
      hold = !bus.out_ready;
      held = {bus.out_last, bus.out_flit};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [PW-1:0] p, logic [3:0] d,
                      logic [4:0] id);
    bit ok;
    ok = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_packet = p;
    bus.in_dest   = d;
    bus.in_id     = id;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    bus.in_valid = 1'b0;
    if (!ok) chk("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_idx(logic [1:0] k);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.out_valid && bus.out_flit[1:0] == k) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("idx_timeout", 64'(0), 64'(1));
  endtask

  task automatic drain(int budget);
    bit ok;
    ok = 1'b0;
    ce = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !bus.out_valid
          && count == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", 64'(ok), 64'(1));
    tick();
  endtask

  logic [PW-1:0] p1;
  logic [3:0]    c_snap;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_packet = '0;
    bus.in_dest   = '0;
    bus.in_id     = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    ce = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_flit", 64'(bus.out_flit), 64'(0));
    chk("rst_last", 64'(bus.out_last), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_idle", 64'(bus.in_ready), 64'(1));
    tick();

    // T1 single packet, latency and streaming
    bus.out_ready = 1'b1;
    p1 = 68'hA_BCDE_F012_3456_789A;
    send(p1, 4'd4, 5'd3);
    @(negedge clk);
    chk("lat_early", 64'(bus.out_valid), 64'(0));
    @(negedge clk);
    chk("lat_valid", 64'(bus.out_valid), 64'(1));
    chk("dest_x", 64'(bus.out_flit[31:30]), 64'(1));
    chk("dest_y", 64'(bus.out_flit[29:28]), 64'(1));
    chk("pay0", 64'(bus.out_flit[27:11]), 64'(p1[67:51]));
    for (int k = 1; k < FLITS; k++) begin
      @(negedge clk);
      chk("stream_valid", 64'(bus.out_valid), 64'(1));
      chk("stream_idx", 64'(bus.out_flit[1:0]), 64'(k));
    end
    chk("t1_last", 64'(bus.out_last), 64'(1));
    tick();
    drain(50);

    // T2 backpressure at idx 1
    send(68'h1_2345_6789_ABCD_EF01, 4'd8, 5'd17);
    wait_idx(2'd1);
    bus.out_ready = 1'b0;
    repeat (5) tick();
    chk("t2_count", 64'(count), 64'(1));
    bus.out_ready = 1'b1;
    drain(50);

    // T3 fill the FIFO
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      send({4'(i), $urandom(), $urandom()},
           4'(i), 5'(i + 1));
    bus.in_valid  = 1'b1;
    bus.in_packet = 68'hF_0000_0000_0000_000F;
    bus.in_dest   = 4'd2;
    bus.in_id     = 5'd31;
    @(negedge clk);
    chk("full_in_ready", 64'(bus.in_ready), 64'(0));
    chk("full_count", 64'(count), 64'(8));
    tick();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    tick();
    bus.in_valid = 1'b0;
    drain(200);
    chk("t3_count", 64'(count), 64'(0));

    // T4 bad destination
    send(68'h5_5555_5555_5555_5555, 4'd9, 5'd4);
    @(negedge clk);
    chk("t4_drop", 64'(drop_err), 64'(1));
    chk("t4_count", 64'(count), 64'(0));
    @(negedge clk);
    chk("t4_drop_end", 64'(drop_err), 64'(0));
    repeat (3) @(negedge clk);
    chk("t4_no_flit", 64'(bus.out_valid), 64'(0));
    tick();

    // T5 reset mid-packet
    send(68'h7_7777_0000_1111_2222, 4'd5, 5'd9);
    wait_idx(2'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_valid", 64'(bus.out_valid), 64'(0));
    chk("t5_count", 64'(count), 64'(0));
    tick();
    send(68'h3_1415_9265_3589_7932, 4'd7, 5'd11);
    drain(50);

    // T6 ce gating mid-stream
    send(68'hC_AFE0_BEEF_DEAD_1234, 4'd6, 5'd21);
    wait_idx(2'd2);
    c_snap = count;
    ce = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t6_valid", 64'(bus.out_valid), 64'(0));
      chk("t6_in_ready", 64'(bus.in_ready), 64'(0));
      chk("t6_count", 64'(count), 64'(c_snap));
      tick();
    end
    ce = 1'b1;
    @(negedge clk);
    chk("t6_resume", 64'(bus.out_valid), 64'(1));
    chk("t6_idx", 64'(bus.out_flit[1:0]), 64'(2));
    tick();
    drain(50);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      ce = ($urandom_range(9) != 0);
      bus.out_ready = ($urandom_range(3) != 0);
      bus.in_valid  = $urandom_range(1);
      bus.in_packet = {4'($urandom()), $urandom(),
                       $urandom()};
      bus.in_dest   = 4'($urandom_range(9));
      bus.in_id     = 5'($urandom());
      rst_n = !(c == 300 || c == 301);
      tick();
    end
    rst_n = 1'b1;
    drain(500);
    chk("end_queue", 64'(sbq.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
